// File: rtl/frequency_pkg.sv
// Shared constants for the gated frequency counter: counter width default
// and the active-low 7-segment glyph table.
package frequency_pkg;

  // Default width of the edge counter and of the latched count.
  localparam int CNT_W_DEF = 8;

  // All segments dark; kept for a future blanking mode.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low hex glyphs, each written a..g from MSB to LSB, 0 = segment lit.
  // Index 15 is listed first so that SEG_TABLE[n] is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/frequency_seven_seg_decoder.sv
// Combinational hex nibble to active-low 7-segment code (seg[0] = a ... seg[6] = g).
module seven_seg_decoder
  import frequency_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] seg
);

  // Table lookup; the MSB of each table entry lands on seg[0] (segment a).
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/frequency.sv
// Gated frequency counter: counts synchronised rising edges of sigin over a
// window of GATE_CYCLES clocks, then latches the count and its low-nibble
// 7-segment glyph for display during the following window.
module frequency
  import frequency_pkg::*;
#(
  parameter int GATE_CYCLES = 100,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             sigin,
  input  logic             clck,
  output logic [0:CNT_W-1] number,
  output logic [0:6]       segment,
  input  logic             rst
);

  localparam logic [15:0]      GATE_LAST = 16'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Synchroniser pair, edge-detector history, gate and edge counters.
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [15:0]      gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered display outputs.
  logic [CNT_W-1:0] number_q, number_d;
  logic [0:6]       segment_q, segment_d;

  logic             edge_det;
  logic             window_end;
  logic [CNT_W-1:0] cnt_plus;
  logic [0:6]       seg_next;

  // Datapath: synchroniser shift, edge detect, saturating count, gate wrap and
  // the window-end latch. cnt_plus folds in an edge seen on the window-end
  // cycle so it lands in this window's result rather than the next.
  always_comb begin
    sync1_d    = sigin;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    edge_det   = sync2_q & ~prev_q;
    window_end = (gate_q == GATE_LAST);
    gate_d     = window_end ? 16'd0 : gate_q + 16'd1;
    cnt_plus   = cnt_q;
    if (edge_det && (cnt_q != CNT_MAX)) begin
      cnt_plus = cnt_q + CNT_W'(1);
    end
    cnt_d    = window_end ? '0 : cnt_plus;
    number_d = window_end ? cnt_plus : number_q;
  end

  // Glyph for the value about to be latched, so both outputs change together.
  seven_seg_decoder u_dec (
    .nibble (number_d[3:0]),
    .seg    (seg_next)
  );

  // Segment register load, kept apart from the datapath block above.
  always_comb begin
    segment_d = segment_q;
    if (window_end) begin
      segment_d = seg_next;
    end
  end

  // State registers; reset wins over a window-end latch in the same cycle.
  always_ff @(posedge clck) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      gate_q    <= 16'd0;
      cnt_q     <= '0;
      number_q  <= '0;
      segment_q <= SEG_TABLE[0];
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
      number_q  <= number_d;
      segment_q <= segment_d;
    end
  end

  // number[0] is the MSB, so the packed copy keeps bit significance intact.
  assign number  = number_q;
  assign segment = segment_q;

endmodule

// File: tb/tb_frequency.sv
// Directed bench for the gated frequency counter. Two instances share the
// stimulus: a 100-cycle gate for most vectors and a 1000-cycle gate for
// saturation. Stimulus pushes expected window counts; monitors pop them when a
// window result appears and check the held value on every other cycle.
module tb_frequency;

  logic       clck;
  logic       rst;
  logic       sigin;
  logic [0:7] number100;
  logic [0:6] seg100;
  logic [0:7] number1k;
  logic [0:6] seg1k;

  logic [7:0] exp_q[$];
  logic [7:0] exp_sat_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int k = 0;
  logic started = 1'b0;

  frequency #(.GATE_CYCLES(100)) dut (
    .sigin   (sigin),
    .clck    (clck),
    .number  (number100),
    .segment (seg100),
    .rst     (rst)
  );

  frequency #(.GATE_CYCLES(1000)) dut_sat (
    .sigin   (sigin),
    .clck    (clck),
    .number  (number1k),
    .segment (seg1k),
    .rst     (rst)
  );

  // Clock and cycles-since-reset counter (k = 0 on a reset edge).
  initial clck = 1'b0;
  always #5 clck = ~clck;

  always @(posedge clck) begin
    started <= 1'b1;
    k       <= rst ? 0 : k + 1;
  end

  // Hand-written glyph table, a..g from MSB, active low.
  function automatic logic [6:0] seg_of(input logic [7:0] v);
    case (v[3:0])
      4'h0: seg_of = 7'b0000001;
      4'h1: seg_of = 7'b1001111;
      4'h2: seg_of = 7'b0010010;
      4'h3: seg_of = 7'b0000110;
      4'h4: seg_of = 7'b1001100;
      4'h5: seg_of = 7'b0100100;
      4'h6: seg_of = 7'b0100000;
      4'h7: seg_of = 7'b0001111;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0000100;
      4'hA: seg_of = 7'b0001000;
      4'hB: seg_of = 7'b1100000;
      4'hC: seg_of = 7'b0110001;
      4'hD: seg_of = 7'b1000010;
      4'hE: seg_of = 7'b0110000;
      default: seg_of = 7'b0111000;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at k=%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Monitor for the 100-cycle instance.
  initial begin
    logic [7:0] cur;
    cur = 8'h00;
    forever begin
      @(negedge clck);
      if (started) begin
        if (k == 0) begin
          cur = 8'h00;
        end else if (k % 100 == 0) begin
          if (exp_q.size() == 0) begin
            check("exp_q_empty", 8'd0, 8'd1);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        check("number100", number100, cur);
        check("segment100", {1'b0, seg100}, {1'b0, seg_of(cur)});
      end
    end
  end

  // Monitor for the 1000-cycle instance.
  initial begin
    logic [7:0] cur;
    cur = 8'h00;
    forever begin
      @(negedge clck);
      if (started) begin
        if (k == 0) begin
          cur = 8'h00;
        end else if (k % 1000 == 0) begin
          if (exp_sat_q.size() == 0) begin
            check("exp_sat_q_empty", 8'd0, 8'd1);
          end else begin
            cur = exp_sat_q.pop_front();
          end
        end
        check("number1k", number1k, cur);
        check("segment1k", {1'b0, seg1k}, {1'b0, seg_of(cur)});
      end
    end
  end

  // Drivers: reset with sigin toggling; pattern drive where sigin for edge k
  // is set on the negedge just before it (k counts from 1 after reset).
  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clck);
      rst   = 1'b1;
      sigin = ~sigin;
    end
  endtask

  // mode 0: hold low; mode 1: square wave of period arg; mode 2: 4-cycle pulse starting at k=arg.
  function automatic logic pattern(input int mode, input int arg, input int kk);
    case (mode)
      1:       pattern = ((kk % arg) >= (arg / 2));
      2:       pattern = (kk >= arg) && (kk < arg + 4);
      default: pattern = 1'b0;
    endcase
  endfunction

  task automatic run_phase(input int mode, input int arg, input int ncyc);
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clck);
      rst   = 1'b0;
      sigin = pattern(mode, arg, i);
    end
  endtask

  task automatic push_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Stimulus sequence.
  initial begin
    rst   = 1'b1;
    sigin = 1'b0;

    // Reset with sigin toggling, then period 10: 10 edges per window.
    do_reset(3);
    push_n(8'd10, 3);
    run_phase(1, 10, 300);

    // sigin held low: zero every window.
    do_reset(2);
    push_n(8'd0, 3);
    run_phase(0, 0, 300);

    // Period 4: 25 per window; an edge lands on the window-end cycle (k=98).
    do_reset(2);
    push_n(8'd25, 2);
    run_phase(1, 4, 200);

    // Single edge detected on the window-end cycle belongs to window 1.
    do_reset(2);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd0);
    run_phase(2, 98, 200);

    // One cycle later it belongs to window 2; total across both stays 1.
    do_reset(2);
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    run_phase(2, 99, 200);

    // Reset 40 cycles into window 2 discards the partial count.
    do_reset(2);
    exp_q.push_back(8'd10);
    exp_q.push_back(8'd25);
    run_phase(1, 10, 140);
    do_reset(1);
    run_phase(1, 4, 100);

    // Reset on the window-end edge beats the latch.
    do_reset(2);
    run_phase(1, 10, 99);
    do_reset(1);

    // Period 2: 49 then 50 per 100-cycle window; 1000-cycle gate saturates at 255.
    do_reset(2);
    exp_q.push_back(8'd49);
    push_n(8'd50, 19);
    exp_sat_q.push_back(8'd255);
    exp_sat_q.push_back(8'd255);
    run_phase(1, 2, 2000);
    run_phase(0, 0, 3);

    check("exp_q_left", 8'(exp_q.size()), 8'd0);
    check("exp_sat_q_left", 8'(exp_sat_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
